// File: rtl/ir_frame_capture.sv
// rtl/ir_frame_capture.sv - serial IR bit accumulator with double-buffered frame output
module ir_frame_capture #(
   parameter int N         = 33,
   parameter int CW        = 7,
   parameter int MSB_FIRST = 1,
   parameter int TIMEOUT   = 4096,
   parameter int TW        = 13
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en,
   input  logic          clear,
   input  logic          bit_strobe,
   input  logic          bit_in,
   input  logic          frame_ack,
   output logic [N-1:0]  frame,
   output logic          frame_valid,
   output logic          busy,
   output logic [CW-1:0] bit_count,
   output logic          overrun,
   output logic          timeout_err
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t         state, state_n;
   logic [N-1:0]   sr, sr_n, sr_shift;
   logic [CW-1:0]  cnt_n;
   logic [TW-1:0]  idle_cnt, idle_n;
   logic [N-1:0]   frame_n;
   logic           valid_n, ovr_n, terr_n;
   logic           accept, done;

   // Next-state logic: clear dominates, en=0 drops a partial frame silently,
   // a strobe beats the timeout on the boundary cycle.
   always_comb begin
      state_n  = state;
      sr_n     = sr;
      cnt_n    = bit_count;
      idle_n   = idle_cnt;
      frame_n  = frame;
      valid_n  = frame_valid;
      ovr_n    = overrun;
      terr_n   = 1'b0;
      done     = 1'b0;
      accept   = bit_strobe & en & ~clear;
      sr_shift = (MSB_FIRST != 0) ? {sr[N-2:0], bit_in} : {bit_in, sr[N-1:1]};

      if (clear) begin
         state_n = IDLE;
         cnt_n   = '0;
         idle_n  = '0;
         valid_n = 1'b0;
         ovr_n   = 1'b0;
      end else begin
         if (frame_valid && frame_ack) begin
            valid_n = 1'b0;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  sr_n    = sr_shift;
                  cnt_n   = CW'(1);
                  idle_n  = '0;
                  state_n = SHIFT;
               end
            end
            SHIFT: begin
               if (!en) begin
                  state_n = IDLE;
                  cnt_n   = '0;
                  idle_n  = '0;
               end else if (accept) begin
                  sr_n   = sr_shift;
                  idle_n = '0;
                  if (bit_count == CW'(N-1)) begin
                     done    = 1'b1;
                     cnt_n   = '0;
                     state_n = IDLE;
                  end else begin
                     cnt_n = bit_count + 1'b1;
                  end
               end else if (idle_cnt == TW'(TIMEOUT-1)) begin
                  state_n = IDLE;
                  cnt_n   = '0;
                  idle_n  = '0;
                  terr_n  = 1'b1;
               end else begin
                  idle_n = idle_cnt + 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               idle_n  = '0;
            end
         endcase
         // A completed frame only replaces the buffer if the consumer has
         // taken (or is taking this cycle) the previous one.
         if (done) begin
            if (frame_valid && !frame_ack) begin
               ovr_n = 1'b1;
            end else begin
               frame_n = sr_shift;
               valid_n = 1'b1;
            end
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         sr          <= '0;
         bit_count   <= '0;
         idle_cnt    <= '0;
         frame       <= '0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         sr          <= sr_n;
         bit_count   <= cnt_n;
         idle_cnt    <= idle_n;
         frame       <= frame_n;
         frame_valid <= valid_n;
         overrun     <= ovr_n;
         timeout_err <= terr_n;
      end
   end

   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_ir_frame_capture.sv
// tb/tb_ir_frame_capture.sv - self-checking bench for ir_frame_capture
module tb_ir_frame_capture;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic en = 1'b0, clear = 1'b0, bit_strobe = 1'b0, bit_in = 1'b0, frame_ack = 1'b0;

   logic [32:0] frame_a;
   logic        valid_a, busy_a, ovr_a, terr_a;
   logic [6:0]  cnt_a;
   logic [7:0]  frame_b;
   logic        valid_b, busy_b, ovr_b, terr_b;
   logic [3:0]  cnt_b;

   always #5 clk = ~clk;

   ir_frame_capture #(.N(33), .CW(7), .MSB_FIRST(1), .TIMEOUT(40), .TW(6)) dut_a (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .bit_strobe(bit_strobe),
      .bit_in(bit_in), .frame_ack(frame_ack), .frame(frame_a), .frame_valid(valid_a),
      .busy(busy_a), .bit_count(cnt_a), .overrun(ovr_a), .timeout_err(terr_a));

   ir_frame_capture #(.N(8), .CW(4), .MSB_FIRST(0), .TIMEOUT(16), .TW(5)) dut_b (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .bit_strobe(bit_strobe),
      .bit_in(bit_in), .frame_ack(frame_ack), .frame(frame_b), .frame_valid(valid_b),
      .busy(busy_b), .bit_count(cnt_b), .overrun(ovr_b), .timeout_err(terr_b));

   // Reference model: list of received bits, clocks since last strobe, output buffer.
   typedef struct packed {
      int          cnt;
      logic [63:0] bits;
      int          gap;
      logic [63:0] frame;
      logic        valid;
      logic        ovr;
      logic        terr;
   } mdl_t;

   mdl_t ma, mb;
   int n_cmp = 0;
   int n_bad = 0;

   function automatic mdl_t step(mdl_t m, int n, bit msb, int tmo,
                                 bit s, bit b, bit e, bit c, bit a);
      mdl_t r;
      bit loaded;
      logic [63:0] f;
      r = m;
      loaded = 0;
      r.terr = 0;
      if (c) begin
         r.cnt = 0; r.gap = 0; r.valid = 0; r.ovr = 0;
         return r;
      end
      if (r.cnt > 0 && !e) begin
         r.cnt = 0; r.gap = 0;
      end else if (s && e) begin
         r.bits[6'(r.cnt)] = b;
         r.cnt = r.cnt + 1;
         r.gap = 0;
         if (r.cnt == n) begin
            f = '0;
            for (int i = 0; i < n; i++) begin
               if (msb) f[6'(n-1-i)] = r.bits[6'(i)];
               else     f[6'(i)]     = r.bits[6'(i)];
            end
            r.cnt = 0;
            if (m.valid && !a) r.ovr = 1;
            else begin r.frame = f; r.valid = 1; loaded = 1; end
         end
      end else if (r.cnt > 0) begin
         r.gap = r.gap + 1;
         if (r.gap == tmo) begin r.cnt = 0; r.gap = 0; r.terr = 1; end
      end
      if (a && m.valid && !loaded) r.valid = 0;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_all();
      chk("a.frame", 64'(frame_a), ma.frame);
      chk("a.valid", 64'(valid_a), 64'(ma.valid));
      chk("a.busy",  64'(busy_a),  64'(ma.cnt > 0));
      chk("a.count", 64'(cnt_a),   64'(ma.cnt));
      chk("a.ovr",   64'(ovr_a),   64'(ma.ovr));
      chk("a.terr",  64'(terr_a),  64'(ma.terr));
      chk("b.frame", 64'(frame_b), mb.frame);
      chk("b.valid", 64'(valid_b), 64'(mb.valid));
      chk("b.busy",  64'(busy_b),  64'(mb.cnt > 0));
      chk("b.count", 64'(cnt_b),   64'(mb.cnt));
      chk("b.ovr",   64'(ovr_b),   64'(mb.ovr));
      chk("b.terr",  64'(terr_b),  64'(mb.terr));
   endtask

   task automatic cycle(input bit s, input bit b, input bit e, input bit c, input bit a);
      bit_strobe = s; bit_in = b; en = e; clear = c; frame_ack = a;
      @(posedge clk);
      ma = step(ma, 33, 1, 40, s, b, e, c, a);
      mb = step(mb, 8, 0, 16, s, b, e, c, a);
      #1;
      cmp_all();
   endtask

   task automatic send_bit(input bit b);
      cycle(0, 0, 1, 0, 0);
      cycle(1, b, 1, 0, 0);
   endtask

   task automatic async_reset(input string nm);
      bit_strobe = 0; frame_ack = 0; clear = 0;
      #2;
      reset_n = 0;
      #1;
      ma = '0; mb = '0;
      chk({nm, ".a.frame"}, 64'(frame_a), 64'd0);
      chk({nm, ".a.valid"}, 64'(valid_a), 64'd0);
      chk({nm, ".a.busy"},  64'(busy_a),  64'd0);
      chk({nm, ".a.count"}, 64'(cnt_a),   64'd0);
      chk({nm, ".b.frame"}, 64'(frame_b), 64'd0);
      chk({nm, ".b.valid"}, 64'(valid_b), 64'd0);
      chk({nm, ".b.ovr"},   64'(ovr_b),   64'd0);
      chk({nm, ".b.terr"},  64'(terr_b),  64'd0);
      @(negedge clk);
      reset_n = 1;
   endtask

   typedef struct {
      logic [7:0] seq;   // seq[7] is sent first
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [6];

   initial begin
      logic [32:0] v;
      int pulses, at_k, p;
      bit prev;

      tbl[0] = '{8'b1000_0000, 8'h01};
      tbl[1] = '{8'b1010_0101, 8'hA5};
      tbl[2] = '{8'b1100_0000, 8'h03};
      tbl[3] = '{8'b0011_1100, 8'h3C};
      tbl[4] = '{8'b1111_0000, 8'h0F};
      tbl[5] = '{8'b0000_0001, 8'h80};

      ma = '0; mb = '0;
      #12;
      chk("rst.a.frame", 64'(frame_a), 64'd0);
      chk("rst.a.busy",  64'(busy_a),  64'd0);
      chk("rst.b.count", 64'(cnt_b),   64'd0);
      chk("rst.b.valid", 64'(valid_b), 64'd0);
      @(negedge clk);
      reset_n = 1;

      // 33-bit alternating frame
      for (int i = 0; i < 33; i++) send_bit((i % 2) == 0);
      chk("t1.frame", 64'(frame_a), 64'h1_5555_5555);
      chk("t1.valid", 64'(valid_a), 64'd1);
      chk("t1.busy",  64'(busy_a),  64'd0);
      cycle(0, 0, 1, 0, 1);
      chk("t1.ack", 64'(valid_a), 64'd0);
      cycle(0, 0, 1, 1, 0);

      // LSB-first table on the 8-bit instance
      for (int r = 0; r < 6; r++) begin
         for (int j = 7; j >= 0; j--) send_bit(tbl[r].seq[j]);
         chk("tbl.frame", 64'(frame_b), 64'(tbl[r].exp));
         chk("tbl.valid", 64'(valid_b), 64'd1);
         cycle(0, 0, 1, 0, 1);
         chk("tbl.ack", 64'(valid_b), 64'd0);
      end
      cycle(0, 0, 1, 1, 0);

      // timeout after 5 bits
      for (int i = 0; i < 5; i++) send_bit(1);
      pulses = 0; at_k = -1;
      for (int k = 1; k <= 24; k++) begin
         cycle(0, 0, 1, 0, 0);
         if (terr_b) begin pulses++; at_k = k; end
      end
      chk("to.pulses", 64'(pulses), 64'd1);
      chk("to.when",   64'(at_k),   64'd16);
      chk("to.count",  64'(cnt_b),  64'd0);
      chk("to.valid",  64'(valid_b), 64'd0);
      cycle(0, 0, 1, 1, 0);
      for (int j = 7; j >= 0; j--) send_bit(tbl[2].seq[j]);
      chk("to.next", 64'(frame_b), 64'h03);
      cycle(0, 0, 1, 1, 0);

      // strobe on the boundary cycle beats the timeout
      send_bit(1);
      for (int k = 0; k < 15; k++) cycle(0, 0, 1, 0, 0);
      cycle(1, 0, 1, 0, 0);
      chk("bnd.terr",  64'(terr_b), 64'd0);
      chk("bnd.count", 64'(cnt_b),  64'd2);
      chk("bnd.busy",  64'(busy_b), 64'd1);
      cycle(0, 0, 1, 1, 0);

      // overrun, then completion with simultaneous ack
      for (int j = 7; j >= 0; j--) send_bit(tbl[1].seq[j]);
      for (int j = 7; j >= 0; j--) send_bit(tbl[3].seq[j]);
      chk("ovr.frame", 64'(frame_b), 64'hA5);
      chk("ovr.flag",  64'(ovr_b),   64'd1);
      cycle(0, 0, 1, 1, 0);
      chk("ovr.clr",   64'(ovr_b),   64'd0);
      chk("ovr.vclr",  64'(valid_b), 64'd0);
      chk("ovr.keep",  64'(frame_b), 64'hA5);
      for (int j = 7; j >= 0; j--) send_bit(tbl[1].seq[j]);
      for (int j = 7; j >= 1; j--) send_bit(tbl[3].seq[j]);
      cycle(0, 0, 1, 0, 0);
      cycle(1, tbl[3].seq[0], 1, 0, 1);
      chk("ack.frame", 64'(frame_b), 64'h3C);
      chk("ack.valid", 64'(valid_b), 64'd1);
      chk("ack.ovr",   64'(ovr_b),   64'd0);
      cycle(0, 0, 1, 1, 0);

      // en drop mid-frame
      for (int i = 0; i < 10; i++) send_bit(1);
      cycle(0, 0, 0, 0, 0);
      chk("en.busy",  64'(busy_a), 64'd0);
      chk("en.count", 64'(cnt_a),  64'd0);
      chk("en.terr",  64'(terr_a), 64'd0);
      v = 33'h1_2345_6789;
      for (int i = 32; i >= 0; i--) send_bit(v[i]);
      chk("en.frame", 64'(frame_a), 64'h1_2345_6789);
      cycle(0, 0, 1, 1, 0);

      // asynchronous reset mid-frame and while holding a frame
      for (int i = 0; i < 5; i++) send_bit(1);
      async_reset("rmid");
      v = 33'h0_DEAD_BEEF;
      for (int i = 32; i >= 0; i--) send_bit(v[i]);
      chk("rv.valid", 64'(valid_a), 64'd1);
      async_reset("rval");
      v = 33'h1_CAFE_F00D;
      for (int i = 32; i >= 0; i--) send_bit(v[i]);
      chk("rr.frame", 64'(frame_a), 64'h1_CAFE_F00D);
      chk("rr.valid", 64'(valid_a), 64'd1);

      // randomized traffic against the model
      prev = 0;
      for (int c = 0; c < 3000; c++) begin
         bit s, e, cl, a;
         p = (c < 1000) ? 50 : (c < 2000) ? 12 : 5;
         s  = !prev && ($urandom_range(0, 99) < p);
         e  = ($urandom_range(0, 199) != 0);
         cl = ($urandom_range(0, 299) == 0);
         a  = ($urandom_range(0, 99) < 15);
         cycle(s, 1'($urandom_range(0, 1)), e, cl, a);
         prev = s;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
